// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate pipeline: op-code encoding, op-select width
// and the width of the completed-transfer counter.
package logic_gate_pkg;

  localparam int unsigned OpWidth    = 3;
  localparam int unsigned CountWidth = 16;

  typedef enum logic [OpWidth-1:0] {
    OpAnd   = 3'd0,
    OpOr    = 3'd1,
    OpNand  = 3'd2,
    OpNor   = 3'd3,
    OpXor   = 3'd4,
    OpXnor  = 3'd5,
    OpNotA  = 3'd6,
    OpPassA = 3'd7
  } op_e;

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Valid/ready bus of the logic gate pipeline: operands and op in, result and count out.
// LOGIC_GATE_PIPE_PARITY_EN adds the staged parity bit of the result.
interface logic_gate_pipe_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0]                        A;
  logic [WIDTH-1:0]                        B;
  logic [logic_gate_pkg::OpWidth-1:0]      op;
  logic                                    in_valid;
  logic                                    in_ready;
  logic [WIDTH-1:0]                        C;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [logic_gate_pkg::CountWidth-1:0]   op_count;
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  logic                                    parity;

  modport master (
    output A, B, op, in_valid, out_ready,
    input  in_ready, C, out_valid, op_count, parity
  );

  modport slave (
    input  A, B, op, in_valid, out_ready,
    output in_ready, C, out_valid, op_count, parity
  );
`else
  modport master (
    output A, B, op, in_valid, out_ready,
    input  in_ready, C, out_valid, op_count
  );

  modport slave (
    input  A, B, op, in_valid, out_ready,
    output in_ready, C, out_valid, op_count
  );
`endif

endinterface

// File: rtl/logic_gate_stage.sv
// One valid/ready register stage: loads when empty or when its content leaves this cycle.
module logic_gate_stage #(
  parameter int unsigned DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DataWidth-1:0] out_data,
  input  logic                 out_ready
);

  logic                 valid_q;
  logic [DataWidth-1:0] data_q;

  // Ready ripples combinationally back from the consumer through every full stage.
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Bitwise gate evaluator feeding a STAGES-deep valid/ready register pipeline.
// Define LOGIC_GATE_PIPE_PARITY_EN to carry XOR-reduced result parity alongside C.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  logic_gate_pipe_if.slave bus
);

`ifdef LOGIC_GATE_PIPE_PARITY_EN
  localparam int unsigned DataW = WIDTH + 1;
`else
  localparam int unsigned DataW = WIDTH;
`endif

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("logic_gate_pipe: WIDTH must be in 1..64");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_gate_pipe: STAGES must be in 1..4");
  end

  logic [WIDTH-1:0]      result;
  logic [DataW-1:0]      payload;
  logic                  stg_valid [STAGES+1];
  logic                  stg_ready [STAGES+1];
  logic [DataW-1:0]      stg_data  [STAGES+1];
  logic [CountWidth-1:0] count_q;

  always_comb begin
    result = '0;
    unique case (op_e'(bus.op))
      OpAnd:   result = bus.A & bus.B;
      OpOr:    result = bus.A | bus.B;
      OpNand:  result = ~(bus.A & bus.B);
      OpNor:   result = ~(bus.A | bus.B);
      OpXor:   result = bus.A ^ bus.B;
      OpXnor:  result = ~(bus.A ^ bus.B);
      OpNotA:  result = ~bus.A;
      OpPassA: result = bus.A;
    endcase
  end

`ifdef LOGIC_GATE_PIPE_PARITY_EN
  assign payload = {^result, result};
`else
  assign payload = result;
`endif

  assign stg_valid[0]      = bus.in_valid;
  assign stg_data[0]       = payload;
  assign stg_ready[STAGES] = bus.out_ready;
  // Hold off the producer while reset is applied so nothing is counted as accepted.
  assign bus.in_ready      = stg_ready[0] && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic_gate_stage #(
      .DataWidth(DataW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (stg_valid[k]),
      .in_data  (stg_data[k]),
      .in_ready (stg_ready[k]),
      .out_valid(stg_valid[k+1]),
      .out_data (stg_data[k+1]),
      .out_ready(stg_ready[k+1])
    );
  end

  assign bus.out_valid = stg_valid[STAGES];
  assign bus.C         = stg_data[STAGES][WIDTH-1:0];
`ifdef LOGIC_GATE_PIPE_PARITY_EN
  assign bus.parity    = stg_data[STAGES][WIDTH];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      count_q <= count_q + CountWidth'(1);
    end
  end

  assign bus.op_count = count_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: queue-based reference model checked every cycle, plus
// directed literal scenarios; a second 1-bit, 2-stage instance covers exact latency.
module tb_logic_gate_pipe;
  import logic_gate_pkg::*;

  localparam int S = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic_gate_pipe_if #(.WIDTH(8)) m ();
  logic_gate_pipe_if #(.WIDTH(1)) s ();

  logic_gate_pipe #(.WIDTH(8), .STAGES(3)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(m)
  );

  logic_gate_pipe #(.WIDTH(1), .STAGES(2)) u_dut_w1 (
    .clk(clk),
    .rst(rst),
    .bus(s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] ref_gate(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0:       return a & b;
      1:       return a | b;
      2:       return ~(a & b);
      3:       return ~(a | b);
      4:       return a ^ b;
      5:       return ~(a ^ b);
      6:       return ~a;
      default: return a;
    endcase
  endfunction

  // Reference model: items in flight with the cycle they were accepted.
  typedef struct {
    logic [7:0] d;
    int         t;
  } item_t;

  item_t q[$];
  int    ref_count = 0;
  bit    exp_ir;
  bit    exp_ov;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_ir = !rst && (q.size() < S || m.out_ready);
      exp_ov = (q.size() > 0) && (cyc >= q[0].t + S);
      check("model_in_ready", m.in_ready, exp_ir);
      check("model_out_valid", m.out_valid, exp_ov);
      check("model_op_count", m.op_count, ref_count);
      if (exp_ov) begin
        check("model_C", m.C, q[0].d);
`ifdef LOGIC_GATE_PIPE_PARITY_EN
        check("model_parity", m.parity, ^q[0].d);
`endif
      end
      if (rst) begin
        q.delete();
        ref_count = 0;
      end else begin
        if (exp_ov && m.out_ready) begin
          void'(q.pop_front());
          ref_count = (ref_count + 1) % 65536;
        end
        if (m.in_valid && exp_ir) q.push_back('{d: ref_gate(m.op, m.A, m.B), t: cyc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [7:0] sweep [8];
  logic       nand_tbl [4];
  logic       par_tbl [2];
  int         first, k, j, got, seen, hit;

  initial begin
    sweep    = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
    nand_tbl = '{1'b1, 1'b1, 1'b1, 1'b0};
    par_tbl  = '{1'b1, 1'b0};
    m.in_valid = 1'b0; m.out_ready = 1'b0; m.A = '0; m.B = '0; m.op = '0;
    s.in_valid = 1'b0; s.out_ready = 1'b1; s.A = '0; s.B = '0; s.op = '0;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_C", m.C, 8'h00);
    check("reset_op_count", m.op_count, 16'h0000);
    check("reset_in_ready", m.in_ready, 1'b0);
    check("reset_out_valid", m.out_valid, 1'b0);
    tick();
    rst = 1'b0;

    // Op sweep on the 8-bit pipe; NAND truth table with exact latency on the 1-bit pipe.
    m.out_ready = 1'b1;
    first = -1;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      m.in_valid = (i < 8);
      m.A = 8'hF0; m.B = 8'hCC; m.op = i[2:0];
      s.in_valid = (i < 4);
      s.A = i[1]; s.B = i[0]; s.op = 3'd2;
      @(negedge clk);
      if (m.out_valid) begin
        if (first < 0) first = i;
        if (k < 8) check("sweep_C", m.C, sweep[k]);
        k++;
      end
      if (i >= 2 && i < 6) begin
        check("w1_out_valid", s.out_valid, 1'b1);
        check("w1_nand_C", s.C, nand_tbl[i-2]);
      end else begin
        check("w1_out_valid_idle", s.out_valid, 1'b0);
      end
      tick();
    end
    s.in_valid = 1'b0;
    check("sweep_latency", first, 3);
    check("sweep_count", k, 8);

    // Backpressure: 5 offered into a 3-deep pipe with the consumer stalled.
    m.out_ready = 1'b0;
    j = 0;
    for (int c = 0; c < 8; c++) begin
      m.in_valid = (j < 5); m.A = 8'h10 + 8'(j); m.op = 3'd7;
      @(negedge clk);
      if (m.in_valid && m.in_ready) j++;
      tick();
    end
    check("stall_accepted", j, 3);
    @(negedge clk);
    check("stall_in_ready", m.in_ready, 1'b0);
    tick();
    m.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      m.in_valid = (j < 5); m.A = 8'h10 + 8'(j); m.op = 3'd7;
      @(negedge clk);
      if (m.in_valid && m.in_ready) j++;
      if (m.out_valid) begin
        check("stall_order", m.C, 8'h10 + 8'(got));
        got++;
      end
      tick();
    end
    check("stall_drained", got, 5);
    check("stall_all_in", j, 5);

    // Reset with two items in flight.
    m.in_valid = 1'b0;
    m.out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m.in_valid = 1'b1; m.A = 8'hA0 + 8'(c); m.op = 3'd7;
      tick();
    end
    m.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_in_ready", m.in_ready, 1'b0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", m.out_valid, 1'b0);
    check("post_rst_op_count", m.op_count, 16'h0000);
    tick();
    m.out_ready = 1'b1;
    m.in_valid = 1'b1; m.A = 8'h5A; m.op = 3'd7;
    tick();
    m.in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m.out_valid) begin
        check("post_rst_first_C", m.C, 8'h5A);
        seen = 1;
        tick();
        break;
      end
      tick();
    end
    check("post_rst_seen", seen, 1);

`ifdef LOGIC_GATE_PIPE_PARITY_EN
    m.in_valid = 1'b1; m.A = 8'h07; m.op = 3'd7;
    tick();
    m.A = 8'h03;
    tick();
    m.in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m.out_valid && got < 2) begin
        check("parity_literal", m.parity, par_tbl[got]);
        got++;
      end
      tick();
    end
    check("parity_count", got, 2);
`endif

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      m.in_valid  = ($urandom_range(0, 9) < 7);
      m.out_ready = ($urandom_range(0, 9) < 6);
      m.A  = 8'($urandom);
      m.B  = 8'($urandom);
      m.op = 3'($urandom_range(0, 7));
      rst  = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    // Stream until op_count reaches 0xFFFF, then one more transfer wraps it.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m.out_ready = 1'b1;
    m.in_valid = 1'b1;
    hit = 0;
    for (int c = 0; c < 70000; c++) begin
      m.A = 8'($urandom); m.B = 8'($urandom); m.op = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (m.op_count == 16'hFFFF) begin
        hit = 1;
        break;
      end
      tick();
    end
    check("wrap_reached_ffff", hit, 1);
    check("wrap_transfer_pending", m.out_valid, 1'b1);
    tick();
    @(negedge clk);
    check("wrap_zero", m.op_count, 16'h0000);
    tick();
    m.in_valid = 1'b0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
